// File: rtl/conv_pkg.sv
// Shared sizing helpers and state type for the convolution accelerator output stage.
package conv_pkg;

   function automatic int k_bits(input int maxk);
      return $clog2(maxk + 1);
   endfunction

   function automatic int x_addr_bits(input int r, input int c);
      return $clog2(r * c);
   endfunction

   // Number of valid convolution outputs for an R x C input and K x K weights.
   function automatic int out_count(input int r, input int c, input int k);
      return (r - k + 1) * (c - k + 1);
   endfunction

   typedef enum logic {IDLE, STREAM} out_state_t;

endpackage

// File: rtl/out_fifo.sv
// Synchronous FIFO with registered storage: an entry is visible at the head the cycle after its write.
// Head reads back as zero while empty, so the output bus is quiet in reset and idle.
module out_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_vld_i,
   input  logic [WIDTH-1:0] wr_dat_i,
   input  logic             rd_rdy_i,
   output logic [WIDTH-1:0] rd_dat_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      cnt_q;
   logic             push;
   logic             pop;

   assign full_o   = (cnt_q == (PW+1)'(DEPTH));
   assign empty_o  = (cnt_q == '0);
   assign push     = wr_vld_i & ~full_o;
   assign pop      = rd_rdy_i & ~empty_o;
   assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_dat_i;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/output_mems.sv
// AXIS transmitter for convolution results: FIFO-buffered, marks the last value of each output matrix.
// OUTPUT_MEMS_TLAST_EN adds AXIS_TLAST with a stored last bit; without it frame end is counted on pops.
module output_mems
   import conv_pkg::*;
#(
   parameter int OUTW  = 32,
   parameter int R     = 9,
   parameter int C     = 8,
   parameter int MAXK  = 4,
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic signed [OUTW-1:0]  in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [k_bits(MAXK)-1:0] K,
   output logic signed [OUTW-1:0]  AXIS_TDATA,
   output logic                    AXIS_TVALID,
   input  logic                    AXIS_TREADY,
`ifdef OUTPUT_MEMS_TLAST_EN
   output logic                    AXIS_TLAST,
`endif
   output logic                    frame_done
);
   localparam int K_BITS  = k_bits(MAXK);
   localparam int FC_BITS = x_addr_bits(R, C);
`ifdef OUTPUT_MEMS_TLAST_EN
   localparam int FW = OUTW + 1;
`else
   localparam int FW = OUTW;
`endif

   logic               rdy_q;
   logic               full;
   logic               empty;
   logic               wr_fire;
   logic               rd_fire;
   logic               fc_step;
   logic               fc_last;
   logic               head_last;
   logic [FW-1:0]      wr_dat;
   logic [FW-1:0]      rd_dat;
   logic [FC_BITS-1:0] fcnt_q;
   logic [K_BITS-1:0]  k_q;
   logic [K_BITS-1:0]  k_eff;
   out_state_t         state_q;
   logic               frame_done_q;

   assign in_ready    = rdy_q & ~full;
   assign AXIS_TVALID = ~empty;
   assign wr_fire     = in_valid & in_ready;
   assign rd_fire     = AXIS_TVALID & AXIS_TREADY;
   assign AXIS_TDATA  = rd_dat[OUTW-1:0];
   assign frame_done  = frame_done_q;

`ifdef OUTPUT_MEMS_TLAST_EN
   assign fc_step    = wr_fire;
   assign wr_dat     = {fc_last, in_data};
   assign head_last  = rd_dat[OUTW];
   assign AXIS_TLAST = rd_dat[OUTW];
`else
   assign fc_step    = rd_fire;
   assign wr_dat     = in_data;
   assign head_last  = fc_last;
`endif

   // The first element of a frame uses the live K; later elements use the copy taken then.
   assign k_eff   = (fcnt_q == '0) ? K : k_q;
   assign fc_last = (int'(fcnt_q) == out_count(R, C, int'(k_eff)) - 1);

   out_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_vld_i (wr_fire),
      .wr_dat_i (wr_dat),
      .rd_rdy_i (AXIS_TREADY),
      .rd_dat_o (rd_dat),
      .full_o   (full),
      .empty_o  (empty)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rdy_q        <= 1'b0;
         state_q      <= IDLE;
         fcnt_q       <= '0;
         k_q          <= '0;
         frame_done_q <= 1'b0;
      end else begin
         rdy_q        <= 1'b1;
         frame_done_q <= rd_fire & head_last;
         if (fc_step) begin
            if (state_q == IDLE) k_q <= K;
            if (fc_last) begin
               fcnt_q  <= '0;
               state_q <= IDLE;
            end else begin
               fcnt_q  <= fcnt_q + FC_BITS'(1);
               state_q <= STREAM;
            end
         end
      end
   end

endmodule
